// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the v4 synchronous FIFO.
//
// Contents:
//   fifo_flags_t  - packed bundle of the four registered status flags
//   wrap_inc      - pointer increment that wraps to 0 on reaching depth
package sync_fifo_pkg;

  // Status flags travel together so they are computed and registered as one unit.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // The increment is made at 32 bits, which is always wider than the pointer.
  // The compare against depth therefore sees the true sum rather than a truncated one.
  // The result is always in 0..depth-1.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input int unsigned depth);
    logic [31:0] nxt;
    nxt = ptr + 32'd1;
    return (nxt >= depth) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrap-around address pointer for the v4 synchronous FIFO.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, pointer -> 0
//   clr    in   synchronous clear to 0, wins over inc
//   inc    in   advance the pointer by one, wrapping DEPTH-1 -> 0
//   ptr    out  current pointer, always in 0..DEPTH-1
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter  int DEPTH  = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_nxt;

  assign ptr_nxt = ADDR_W'(wrap_inc(32'(ptr), DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/sync_fifo_v4.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes.
// DEPTH may be any integer >= 2.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of contents, count, hwm and flags
//   wr_valid/wr_ready     write handshake; wr_ready = !full
//   data_in               write payload
//   rd_valid/rd_ready     read handshake; rd_valid = !empty
//   data_out              head entry, combinational from storage
//   full, empty           registered occupancy flags
//   almost_full           registered, occupancy >= AF_THRESH
//   almost_empty          registered, occupancy <= AE_THRESH
//   count                 registered occupancy
//   hwm                   peak occupancy since reset, flush or hwm_clr
//   hwm_clr               reload hwm with the next occupancy
module sync_fifo_v4
  import sync_fifo_pkg::*;
#(
  parameter  int  DEPTH     = 2,
  parameter  type T         = logic,
  parameter  int  AF_THRESH = DEPTH - 1,
  parameter  int  AE_THRESH = 1,
  localparam int  ADDR_W    = $clog2(DEPTH),
  localparam int  CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  T                 data_in,
  output logic             rd_valid,
  input  logic             rd_ready,
  output T                 data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] hwm,
  input  logic             hwm_clr
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_v4: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_v4: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_v4: AE_THRESH must be in 0..DEPTH-1");
  end

  T                  mem [DEPTH];
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              wr_fire;
  logic              rd_fire;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  hwm_q;
  logic [CNT_W-1:0]  hwm_nxt;
  fifo_flags_t       flags_q;
  fifo_flags_t       flags_nxt;

  // Both handshakes are qualified only by registered flags.
  // This keeps ready and valid free of any input-to-output combinational path.
  assign wr_ready = !flags_q.full;
  assign rd_valid = !flags_q.empty;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_fire),
    .ptr   (waddr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_raddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_fire),
    .ptr   (raddr)
  );

  // Storage has no reset.
  // A write that coincides with flush is dropped, so stale data cannot reappear.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      mem[waddr] <= data_in;
    end
  end

  assign data_out = mem[raddr];

  // Next occupancy. Flush forces the empty state.
  // Otherwise a simultaneous read and write cancel out.
  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end
  end

  // The flags are derived from the next occupancy and then registered.
  // They therefore always agree with count in the same cycle.
  always_comb begin
    flags_nxt              = '0;
    flags_nxt.full         = (count_nxt == CNT_W'(DEPTH));
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.almost_full  = (count_nxt >= CNT_W'(AF_THRESH));
    flags_nxt.almost_empty = (count_nxt <= CNT_W'(AE_THRESH));
  end

  // High-water mark priority:
  //   1. flush clears it to 0
  //   2. hwm_clr reloads it with the new occupancy
  //   3. otherwise it tracks the running maximum
  always_comb begin
    hwm_nxt = hwm_q;
    if (flush) begin
      hwm_nxt = '0;
    end else if (hwm_clr) begin
      hwm_nxt = count_nxt;
    end else if (count_nxt > hwm_q) begin
      hwm_nxt = count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hwm_q   <= '0;
      flags_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      count_q <= count_nxt;
      hwm_q   <= hwm_nxt;
      flags_q <= flags_nxt;
    end
  end

  assign count        = count_q;
  assign hwm          = hwm_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;

endmodule

// File: tb/tb_sync_fifo_v4.sv
// Self-checking bench for sync_fifo_v4.
// Configuration: DEPTH=5, AF_THRESH=4, AE_THRESH=1, 8-bit payload.
module tb_sync_fifo_v4;

  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CNT_W = 3;

  typedef logic [7:0] data_t;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             flush    = 1'b0;
  logic             wr_valid = 1'b0;
  logic             rd_ready = 1'b0;
  logic             hwm_clr  = 1'b0;
  data_t            data_in  = '0;
  data_t            data_out;
  logic             wr_ready, rd_valid, full, empty, almost_full, almost_empty;
  logic [CNT_W-1:0] count, hwm;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue plus a peak tracker.
  data_t m_q[$];
  int    m_hwm = 0;

  typedef struct {
    logic  wv;
    data_t din;
    logic  rr;
    int    cnt;
    logic  full;
    logic  empty;
    logic  af;
    logic  ae;
    int    hwm;
    logic  dchk;
    data_t dout;
  } vec_t;

  vec_t vecs[11];

  sync_fifo_v4 #(
    .DEPTH     (DEPTH),
    .T         (data_t),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .data_in      (data_in),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .hwm          (hwm),
    .hwm_clr      (hwm_clr)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and lets one clock edge pass.
  // The model is then advanced using the occupancy it held before that edge.
  task automatic applyStimulus(input logic wv, input data_t din, input logic rr,
                               input logic fl, input logic hc);
    bit wr_ok, rd_ok;
    wr_valid = wv;
    data_in  = din;
    rd_ready = rr;
    flush    = fl;
    hwm_clr  = hc;
    wr_ok = wv && (m_q.size() < DEPTH);
    rd_ok = rr && (m_q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      m_q.delete();
      m_hwm = 0;
    end else begin
      if (rd_ok) void'(m_q.pop_front());
      if (wr_ok) m_q.push_back(din);
      if (hc) m_hwm = m_q.size();
      else if (m_q.size() > m_hwm) m_hwm = m_q.size();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    hwm_clr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = m_q.size();
    cmp({tag, ".count"},        int'(count),        n);
    cmp({tag, ".full"},         int'(full),         (n == DEPTH) ? 1 : 0);
    cmp({tag, ".empty"},        int'(empty),        (n == 0) ? 1 : 0);
    cmp({tag, ".almost_full"},  int'(almost_full),  (n >= AF) ? 1 : 0);
    cmp({tag, ".almost_empty"}, int'(almost_empty), (n <= AE) ? 1 : 0);
    cmp({tag, ".wr_ready"},     int'(wr_ready),     (n < DEPTH) ? 1 : 0);
    cmp({tag, ".rd_valid"},     int'(rd_valid),     (n > 0) ? 1 : 0);
    cmp({tag, ".hwm"},          int'(hwm),          m_hwm);
    if (n > 0) cmp({tag, ".data_out"}, int'(data_out), int'(m_q[0]));
    cmp({tag, ".waddr_range"}, (dut.waddr < 3'd5) ? 1 : 0, 1);
    cmp({tag, ".raddr_range"}, (dut.raddr < 3'd5) ? 1 : 0, 1);
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, ".count"},        int'(count),        0);
    cmp({tag, ".hwm"},          int'(hwm),          0);
    cmp({tag, ".empty"},        int'(empty),        1);
    cmp({tag, ".full"},         int'(full),         0);
    cmp({tag, ".almost_empty"}, int'(almost_empty), 1);
    cmp({tag, ".almost_full"},  int'(almost_full),  0);
    cmp({tag, ".rd_valid"},     int'(rd_valid),     0);
    cmp({tag, ".wr_ready"},     int'(wr_ready),     1);
  endtask

  initial begin
    // Fill to full with one held extra write, then drain in order.
    vecs[0]  = '{1'b1, 8'h10, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h10};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h10};
    vecs[2]  = '{1'b1, 8'h12, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 8'h10};
    vecs[3]  = '{1'b1, 8'h13, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 8'h10};
    vecs[4]  = '{1'b1, 8'h14, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b1, 8'h10};
    vecs[5]  = '{1'b1, 8'h15, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b1, 8'h10};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b1, 8'h11};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 8'h12};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 8'h13};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b1, 8'h14};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].din, vecs[i].rr, 1'b0, 1'b0);
      cmp($sformatf("vec%0d.count", i),    int'(count),        vecs[i].cnt);
      cmp($sformatf("vec%0d.full", i),     int'(full),         int'(vecs[i].full));
      cmp($sformatf("vec%0d.empty", i),    int'(empty),        int'(vecs[i].empty));
      cmp($sformatf("vec%0d.af", i),       int'(almost_full),  int'(vecs[i].af));
      cmp($sformatf("vec%0d.ae", i),       int'(almost_empty), int'(vecs[i].ae));
      cmp($sformatf("vec%0d.hwm", i),      int'(hwm),          vecs[i].hwm);
      cmp($sformatf("vec%0d.wr_ready", i), int'(wr_ready),     int'(!vecs[i].full));
      cmp($sformatf("vec%0d.rd_valid", i), int'(rd_valid),     int'(!vecs[i].empty));
      if (vecs[i].dchk) cmp($sformatf("vec%0d.data_out", i), int'(data_out), int'(vecs[i].dout));
    end

    // Repeated 3-in/3-out bursts walk both pointers across the wrap point.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b1, data_t'(8'h20 + r * 3 + k), 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_wr");
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_rd");
      end
    end

    // Streaming at a steady occupancy of 2.
    // At full, a concurrent request may only read.
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, data_t'(8'h32 + i), 1'b1, 1'b0, 1'b0);
      cmp("stream.count2", int'(count), 2);
      checkOutput("stream");
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, data_t'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    cmp("prefull.count", int'(count), 5);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    cmp("full_concurrent.count", int'(count), 4);
    checkOutput("full_concurrent");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("drain");

    // Flush with 3 entries while a write is offered in the same cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, data_t'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    cmp("flush.count", int'(count), 0);
    cmp("flush.empty", int'(empty), 1);
    cmp("flush.hwm",   int'(hwm),   0);
    checkOutput("flush");
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cmp("post_flush.data_out", int'(data_out), 8'h5A);
    cmp("post_flush.count",    int'(count),    1);

    // Asynchronous reset dropped between clock edges during a burst.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, data_t'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b1;
    data_in  = 8'h99;
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_q.delete();
    m_hwm = 0;
    applyStimulus(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("after_reset");

    // Peak of 5, fall back to 3, then reload the high-water mark.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, data_t'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    cmp("peak.hwm", int'(hwm), 5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cmp("hwm_clr.hwm", int'(hwm), 3);
    checkOutput("hwm_clr");

    // Random traffic with rare flush and hwm_clr.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), data_t'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      checkOutput("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
